// File: rtl/mod3_frame_tx_if.sv
// Handshake and serial-output bundle for mod3_frame_tx.
// The slave modport belongs to the framer; the master modport belongs to the word source and line consumer.
interface mod3_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;
    logic              o_bit;
    logic              o_bit_valid;
    logic              o_frame_end;

    modport master (
        output i_valid,
        output i_data,
        input  o_ready,
        input  o_bit,
        input  o_bit_valid,
        input  o_frame_end
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_ready,
        output o_bit,
        output o_bit_valid,
        output o_frame_end
    );
endinterface

// File: rtl/mod3_frame_tx.sv
// Serialises DATA_W-bit words MSB first and appends two pad bits so that every
// frame carries a multiple-of-three count of ones for the downstream mod-3 detector.
module mod3_frame_tx #(
    parameter int DATA_W = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    mod3_frame_tx_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_DATA = 2'b01;
    localparam logic [1:0] S_PAD  = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        res_q, res_d;
    logic              bit_q, bit_d;
    logic              bvld_q, bvld_d;
    logic              fend_q, fend_d;
    logic              live_q;
    logic              ready;
    logic [1:0]        res_inc;

    function automatic logic [1:0] mod3_inc(input logic [1:0] r, input logic b);
        if (!b) return r;
        case (r)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // live_q keeps o_ready low until the first edge after reset release.
    assign ready   = live_q && (state_q == S_IDLE);
    assign res_inc = mod3_inc(res_q, bit_q);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bit_d   = 1'b0;
        bvld_d  = 1'b0;
        fend_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid && ready) begin
                    state_d = S_DATA;
                    sh_d    = bus.i_data;
                    cnt_d   = '0;
                    res_d   = 2'd0;
                    bit_d   = bus.i_data[DATA_W-1];
                    bvld_d  = 1'b1;
                end
            end
            S_DATA: begin
                // bit_q is the payload bit on the line this cycle; fold it into the residue.
                res_d  = res_inc;
                bvld_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_PAD;
                    cnt_d   = '0;
                    bit_d   = (res_inc != 2'd0);
                end else begin
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q + CNT_W'(1);
                    bit_d = sh_q[DATA_W-2];
                end
            end
            S_PAD: begin
                if (cnt_q == '0) begin
                    cnt_d  = CNT_W'(1);
                    bit_d  = (res_q == 2'd1);
                    bvld_d = 1'b1;
                    fend_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                res_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            res_q   <= 2'd0;
            bit_q   <= 1'b0;
            bvld_q  <= 1'b0;
            fend_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bit_q   <= bit_d;
            bvld_q  <= bvld_d;
            fend_q  <= fend_d;
            live_q  <= 1'b1;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_bit       = bit_q;
    assign bus.o_bit_valid = bvld_q;
    assign bus.o_frame_end = fend_q;
endmodule

// File: doc/mod3_frame_tx.md
MOD3_FRAME_TX -- requirements
Module: mod3_frame_tx

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits; legal range 2..32.
REQ-002 Port: i_clk  input  1  rising-edge clock for all state.
REQ-003 Port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: i_valid  input  1  payload word offered on i_data.
REQ-005 Port: i_data  input  DATA_W  payload word; sampled only on handshake.
REQ-006 Port: o_ready  output  1  block can accept a word this cycle.
REQ-007 Port: o_bit  output  1  serial line to the mod-3 ones-count detector; registered.
REQ-008 Port: o_bit_valid  output  1  o_bit carries a frame bit this cycle; registered.
REQ-009 Port: o_frame_end  output  1  single-cycle pulse coincident with the last frame bit; registered.

Function
REQ-010 A frame SHALL be DATA_W payload bits, MSB first, followed by 2 pad bits.
REQ-011 The pad SHALL make the frame's total count of 1 bits divisible by 3.
REQ-012 Pad encoding SHALL depend on payload ones residue r = (ones mod 3): r=0 gives 00, r=1 gives 11, r=2 gives 10 (first pad bit sent first).
REQ-013 r SHALL be accumulated serially in a 2-bit mod-3 counter as each payload bit is sent, with 2 wrapping to 0 on a 1 bit; a popcount of the whole word is not used.
REQ-014 FSM states SHALL be IDLE, DATA and PAD; an unused encoding SHALL return to IDLE on the next clock.
REQ-015 In IDLE, o_ready=1; a handshake (i_valid & o_ready at a rising edge) SHALL load i_data into the shift register, clear r and the bit counter, and move to DATA.
REQ-016 In IDLE with i_valid=0, the block SHALL remain in IDLE.
REQ-017 In DATA, o_ready=0 and o_bit_valid=1; o_bit SHALL be the current MSB, shifting once per cycle for exactly DATA_W cycles, then move to PAD.
REQ-018 In PAD, o_bit_valid=1 for exactly 2 cycles carrying the REQ-012 pad; o_frame_end=1 in the second cycle; the block SHALL then return to IDLE.
REQ-019 Latency: with a handshake at edge N, payload MSB SHALL appear on o_bit in the cycle after edge N; the frame SHALL occupy DATA_W+2 consecutive cycles.
REQ-020 Throughput: o_ready SHALL reassert in the cycle after the frame_end cycle, giving a minimum frame period of DATA_W+3 cycles.
REQ-021 Whenever o_bit_valid=0, o_bit SHALL be 0, so an idle line does not advance the detector.
REQ-022 i_valid and i_data SHALL be ignored while o_ready=0; no word is queued or lost silently, because the source holds i_valid until handshake.
REQ-023 i_data changing after the handshake SHALL NOT affect the frame in flight.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately force: state IDLE, o_bit=0, o_bit_valid=0, o_frame_end=0, r=0, bit counter=0, shift register=0.
REQ-025 o_ready SHALL be 0 while reset is asserted and 1 from the first clock edge after deassertion.
REQ-026 Reset mid-frame SHALL abandon the frame with no pad emitted; the next handshake SHALL start a fresh frame.

Verification
REQ-027 Send 8'h00: o_bit = 0000000000; o_frame_end is high in frame cycle 10 only.
REQ-028 Send 8'hFF: payload 11111111 gives r=2, so pad is 10, for 9 ones total.
REQ-029 Send 8'h80, then 8'h07: pads are 11 and 00 respectively; the second handshake occurs no earlier than 11 cycles after the first.
REQ-030 Hold i_valid high with changing i_data during a frame: the output frame matches the word captured at handshake, and o_ready stays 0 until after frame_end.
REQ-031 Assert i_rst_n low in frame cycle 5 of 8'hAA: all outputs are 0 immediately; after release, 8'h01 produces 00000001 11.
REQ-032 Connect to the mod-3 ones-count detector and send 1000 random words back-to-back: the detector output is 1 at every frame boundary and after reset.
